// File: rtl/tick_gen_pkg.sv
// Shared constants and the per-channel action type for the tick generator.
// Used by tick_gen_ch and tick_gen_multi; optional square output is controlled by TICK_GEN_SQUARE_EN.
package tick_gen_pkg;

    localparam int CLK_HZ    = 50_000_000;
    localparam int DIV_1HZ   = 50_000_000;
    localparam int DIV_8HZ   = 6_250_000;
    localparam int EV_W_DEF  = 8;
    localparam int CNT_W_DEF = 26;

    // Action taken by a channel on the coming edge; priority resync > pause > count.
    typedef enum logic [1:0] {
        ACT_RESYNC,
        ACT_HOLD,
        ACT_WRAP,
        ACT_STEP
    } ch_act_e;

endpackage

// File: rtl/tick_gen_ch.sv
// One tick channel: phase counter, clamped effective divisor, tick strobe, event counter.
// Square-wave flop exists only when TICK_GEN_SQUARE_EN is defined; otherwise o_sq is tied low.
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int SPEED_W = 2,
    parameter int EV_W    = EV_W_DEF
) (
    input  logic               i_clk_50m,
    input  logic               i_rst,
    input  logic               i_pause,
    input  logic               i_resync,
    input  logic [SPEED_W-1:0] i_speed,
    input  logic [CNT_W-1:0]   i_div,
    output logic               o_tick,
    output logic [EV_W-1:0]    o_ev_cnt,
    output logic               o_sq
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic [EV_W-1:0]  r_ev_cnt;
    logic [CNT_W-1:0] w_shift;
    logic [CNT_W-1:0] w_eff;
    ch_act_e          w_act;

    always_comb begin
        w_shift = i_div >> i_speed;
        w_eff   = (w_shift == '0) ? CNT_W'(1) : w_shift;
    end

    // Compare with >= so a divisor shrink below the current phase wraps at once.
    always_comb begin
        w_act = ACT_STEP;
        if (i_resync) begin
            w_act = ACT_RESYNC;
        end else if (i_pause) begin
            w_act = ACT_HOLD;
        end else if (r_cnt >= w_eff - CNT_W'(1)) begin
            w_act = ACT_WRAP;
        end
    end

    always_ff @(posedge i_clk_50m or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_tick   <= 1'b0;
            r_ev_cnt <= '0;
        end else begin
            case (w_act)
                ACT_RESYNC: begin
                    r_cnt    <= '0;
                    r_tick   <= 1'b0;
                    r_ev_cnt <= '0;
                end
                ACT_HOLD: begin
                    r_tick   <= 1'b0;
                end
                ACT_WRAP: begin
                    r_cnt    <= '0;
                    r_tick   <= 1'b1;
                    r_ev_cnt <= r_ev_cnt + EV_W'(1);
                end
                ACT_STEP: begin
                    r_cnt    <= r_cnt + CNT_W'(1);
                    r_tick   <= 1'b0;
                end
                default: begin
                    r_tick   <= 1'b0;
                end
            endcase
        end
    end

    assign o_tick   = r_tick;
    assign o_ev_cnt = r_ev_cnt;

`ifdef TICK_GEN_SQUARE_EN
    logic r_sq;

    always_ff @(posedge i_clk_50m or posedge i_rst) begin
        if (i_rst) begin
            r_sq <= 1'b0;
        end else if (w_act == ACT_RESYNC) begin
            r_sq <= 1'b0;
        end else if (w_act == ACT_WRAP) begin
            r_sq <= ~r_sq;
        end
    end

    assign o_sq = r_sq;
`else
    assign o_sq = 1'b0;
`endif

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel clock-enable generator: slices packed config/outputs and fans out shared controls.
// Define TICK_GEN_SQUARE_EN to build the per-channel square-wave outputs.
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int SPEED_W = 2,
    parameter int EV_W    = EV_W_DEF
) (
    input  logic                   i_clk_50m,
    input  logic                   i_rst,
    input  logic                   i_pause,
    input  logic                   i_resync,
    input  logic [SPEED_W-1:0]     i_speed,
    input  logic [N_CH*CNT_W-1:0]  i_div_cfg,
    output logic [N_CH-1:0]        o_tick,
    output logic [N_CH*EV_W-1:0]   o_ev_cnt,
    output logic [N_CH-1:0]        o_sq
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tick_gen_ch #(
            .CNT_W   (CNT_W),
            .SPEED_W (SPEED_W),
            .EV_W    (EV_W)
        ) u_ch (
            .i_clk_50m (i_clk_50m),
            .i_rst     (i_rst),
            .i_pause   (i_pause),
            .i_resync  (i_resync),
            .i_speed   (i_speed),
            .i_div     (i_div_cfg[g*CNT_W +: CNT_W]),
            .o_tick    (o_tick[g]),
            .o_ev_cnt  (o_ev_cnt[g*EV_W +: EV_W]),
            .o_sq      (o_sq[g])
        );
    end

endmodule
